// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight-write tracker for the 5-stage pipeline.
//
// ID records each issued destination, WB retires it, and load completion clears
// the load-busy state so a forwarding pipeline can stop waiting on that register.
// A source that must wait, or an issue that would overflow its pending counter,
// raises hazard_detected and blocks the issue from being recorded.
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-low reset
//   forward_EN                  1: only load-busy sources stall; 0: any pending write stalls
//   issue_valid/_wb_en/_is_load ID issue request and its writeback / load attributes
//   issue_dest                  destination of the issuing instruction
//   source1_ID, source2_ID      ID source operands (source2 gated by src2_is_valid)
//   retire_valid, retire_dest   WB register write retiring a pending write
//   load_done, load_done_dest   load data returned, now forwardable
//   hazard_detected, issue_fire combinational stall / accepted-issue indications
//   sb_error                    sticky: retire or load_done with nothing pending
//   busy_count                  total pending writes over all registers
module reg_scoreboard #(
   parameter int unsigned REG_LENGTH = 5,
   parameter int unsigned CNT_W      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        forward_EN,
   input  logic                        issue_valid,
   input  logic                        issue_wb_en,
   input  logic                        issue_is_load,
   input  logic [REG_LENGTH-1:0]       issue_dest,
   input  logic [REG_LENGTH-1:0]       source1_ID,
   input  logic [REG_LENGTH-1:0]       source2_ID,
   input  logic                        src2_is_valid,
   input  logic                        retire_valid,
   input  logic [REG_LENGTH-1:0]       retire_dest,
   input  logic                        load_done,
   input  logic [REG_LENGTH-1:0]       load_done_dest,
   output logic                        hazard_detected,
   output logic                        issue_fire,
   output logic                        sb_error,
   output logic [REG_LENGTH+CNT_W-1:0] busy_count
);

   localparam int unsigned NumRegs = 2 ** REG_LENGTH;
   localparam int unsigned BusyW   = REG_LENGTH + CNT_W;
   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [CNT_W-1:0] pend_q  [NumRegs];
   logic [CNT_W-1:0] pend_d  [NumRegs];
   logic [CNT_W-1:0] lbusy_q [NumRegs];
   logic [CNT_W-1:0] lbusy_d [NumRegs];
   logic             sb_error_q, sb_error_d;
   logic [BusyW-1:0] busy_q, busy_d;

   logic src1_wait, src2_wait, struct_stall;
   logic pend_inc, lbusy_inc;
   logic retire_act, retire_dec;
   logic load_act, load_dec;

   // Hazard check looks only at registered state: same-cycle retire/load_done
   // take effect from the next cycle.
   always_comb begin
      src1_wait = 1'b0;
      src2_wait = 1'b0;
      if (source1_ID != '0) begin
         src1_wait = forward_EN ? (lbusy_q[source1_ID] != '0) : (pend_q[source1_ID] != '0);
      end
      if (src2_is_valid && (source2_ID != '0)) begin
         src2_wait = forward_EN ? (lbusy_q[source2_ID] != '0) : (pend_q[source2_ID] != '0);
      end
      // r0 is never tracked, so its counter stays 0 and cannot trip this.
      struct_stall    = issue_wb_en && (pend_q[issue_dest] == CntMax);
      hazard_detected = issue_valid && (src1_wait || src2_wait || struct_stall);
      issue_fire      = issue_valid && !hazard_detected;
   end

   // Event qualification; all tests use pre-edge counter values.
   always_comb begin
      pend_inc   = issue_fire && issue_wb_en && (issue_dest != '0);
      // Load count saturates in case loads retire before their data returns.
      lbusy_inc  = pend_inc && issue_is_load && (lbusy_q[issue_dest] != CntMax);
      retire_act = retire_valid && (retire_dest != '0);
      retire_dec = retire_act && (pend_q[retire_dest] != '0);
      load_act   = load_done && (load_done_dest != '0);
      load_dec   = load_act && (lbusy_q[load_done_dest] != '0);
   end

   // Next-state counters; applying the updates in sequence nets out
   // simultaneous events on the same register.
   always_comb begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
         pend_d[r]  = pend_q[r];
         lbusy_d[r] = lbusy_q[r];
      end
      if (retire_dec) begin
         pend_d[retire_dest] = pend_d[retire_dest] - CntOne;
      end
      if (pend_inc) begin
         pend_d[issue_dest] = pend_d[issue_dest] + CntOne;
      end
      if (load_dec) begin
         lbusy_d[load_done_dest] = lbusy_d[load_done_dest] - CntOne;
      end
      if (lbusy_inc) begin
         lbusy_d[issue_dest] = lbusy_d[issue_dest] + CntOne;
      end
   end

   always_comb begin
      sb_error_d = sb_error_q || (retire_act && !retire_dec) || (load_act && !load_dec);
      busy_d     = busy_q + BusyW'(pend_inc) - BusyW'(retire_dec);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned r = 0; r < NumRegs; r++) begin
            pend_q[r]  <= '0;
            lbusy_q[r] <= '0;
         end
         sb_error_q <= 1'b0;
         busy_q     <= '0;
      end else begin
         for (int unsigned r = 0; r < NumRegs; r++) begin
            pend_q[r]  <= pend_d[r];
            lbusy_q[r] <= lbusy_d[r];
         end
         sb_error_q <= sb_error_d;
         busy_q     <= busy_d;
      end
   end

   assign sb_error   = sb_error_q;
   assign busy_count = busy_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized scoreboard bench for reg_scoreboard against a counting reference model.
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       forward_EN = 1'b0;
   logic       issue_valid = 1'b0, issue_wb_en = 1'b0, issue_is_load = 1'b0;
   logic [4:0] issue_dest = '0, source1_ID = '0, source2_ID = '0;
   logic       src2_is_valid = 1'b0;
   logic       retire_valid = 1'b0;
   logic [4:0] retire_dest = '0;
   logic       load_done = 1'b0;
   logic [4:0] load_done_dest = '0;
   logic       hazard_detected, issue_fire, sb_error;
   logic [6:0] busy_count;

   reg_scoreboard #(.REG_LENGTH(5), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .forward_EN(forward_EN),
      .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_is_load(issue_is_load),
      .issue_dest(issue_dest), .source1_ID(source1_ID), .source2_ID(source2_ID),
      .src2_is_valid(src2_is_valid), .retire_valid(retire_valid), .retire_dest(retire_dest),
      .load_done(load_done), .load_done_dest(load_done_dest),
      .hazard_detected(hazard_detected), .issue_fire(issue_fire),
      .sb_error(sb_error), .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hz;
      int fire;
      int err;
      int busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   // Reference model: plain per-register counts of writes and loads in flight.
   int pend_m[32];
   int lb_m[32];
   int err_m = 0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("hazard_detected", int'(hazard_detected), e.hz);
         chk("issue_fire", int'(issue_fire), e.fire);
         chk("sb_error", int'(sb_error), e.err);
         chk("busy_count", int'(busy_count), e.busy);
      end
   end

   function automatic bit must_wait(input int r);
      if (r == 0) return 1'b0;
      return forward_EN ? (lb_m[r] != 0) : (pend_m[r] != 0);
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
      issue_valid = 0; issue_wb_en = 0; issue_is_load = 0; issue_dest = 0;
      source1_ID = 0; source2_ID = 0; src2_is_valid = 0;
      retire_valid = 0; retire_dest = 0; load_done = 0; load_done_dest = 0;
   endtask

   // Push expected outputs for the inputs now applied, then advance the model
   // to the state it will hold after the coming rising edge.
   task automatic predict();
      exp_t e;
      bit   hz, fire, dec_p, dec_l;
      int   sum = 0;
      if (!rst) begin
         foreach (pend_m[i]) begin pend_m[i] = 0; lb_m[i] = 0; end
         err_m = 0;
      end
      hz = issue_valid && (must_wait(int'(source1_ID)) ||
           (src2_is_valid && must_wait(int'(source2_ID))) ||
           (issue_wb_en && pend_m[issue_dest] == 3));
      fire = issue_valid && !hz;
      foreach (pend_m[i]) sum += pend_m[i];
      e.hz = int'(hz); e.fire = int'(fire); e.err = err_m; e.busy = sum;
      exp_q.push_back(e);
      if (rst) begin
         dec_p = 0; dec_l = 0;
         if (retire_valid && retire_dest != 0) begin
            if (pend_m[retire_dest] > 0) dec_p = 1; else err_m = 1;
         end
         if (load_done && load_done_dest != 0) begin
            if (lb_m[load_done_dest] > 0) dec_l = 1; else err_m = 1;
         end
         if (fire && issue_wb_en && issue_dest != 0) begin
            pend_m[issue_dest]++;
            if (issue_is_load && lb_m[issue_dest] < 3) lb_m[issue_dest]++;
         end
         if (dec_p) pend_m[retire_dest]--;
         if (dec_l) lb_m[load_done_dest]--;
      end
   endtask

   task automatic issue_to(input int d, input bit ld);
      issue_valid = 1; issue_wb_en = 1; issue_is_load = ld; issue_dest = 5'(d);
   endtask

   initial begin
      foreach (pend_m[i]) begin pend_m[i] = 0; lb_m[i] = 0; end
      // Reset held for two cycles, then released.
      next(); predict();
      next(); predict();
      next(); rst = 1; predict();

      // Non-forwarding RAW on r5.
      forward_EN = 0;
      next(); issue_to(5, 0); predict();
      next(); issue_valid = 1; source1_ID = 5; predict();
      next(); retire_valid = 1; retire_dest = 5; predict();
      next(); issue_valid = 1; source1_ID = 5; predict();

      // Forwarding: ALU result never stalls, load stalls until data returns.
      forward_EN = 1;
      next(); issue_to(7, 0); predict();
      next(); issue_valid = 1; source1_ID = 7; predict();
      next(); issue_to(8, 1); predict();
      next(); issue_valid = 1; source2_ID = 8; src2_is_valid = 1; predict();
      next(); issue_valid = 1; source2_ID = 8; src2_is_valid = 0; predict();
      next(); load_done = 1; load_done_dest = 8; predict();
      next(); issue_valid = 1; source2_ID = 8; src2_is_valid = 1; predict();
      next(); retire_valid = 1; retire_dest = 7; predict();
      next(); retire_valid = 1; retire_dest = 8; predict();

      // Saturation of r3's pending count.
      forward_EN = 0;
      repeat (3) begin next(); issue_to(3, 0); predict(); end
      next(); issue_to(3, 0); predict();
      next(); issue_to(3, 0); retire_valid = 1; retire_dest = 3; predict();
      next(); issue_to(3, 0); predict();
      repeat (3) begin next(); retire_valid = 1; retire_dest = 3; predict(); end

      // Same-cycle issue + retire on r4.
      next(); issue_to(4, 0); predict();
      next(); issue_to(4, 0); retire_valid = 1; retire_dest = 4; predict();
      next(); predict();

      // Retire with nothing pending, and r0 traffic.
      next(); retire_valid = 1; retire_dest = 9; predict();
      next(); issue_to(0, 0); predict();
      next(); issue_valid = 1; source1_ID = 0; source2_ID = 0; src2_is_valid = 1;
      retire_valid = 1; retire_dest = 0; predict();
      next(); predict();

      // Build six more pending writes, then reset asynchronously mid-cycle.
      for (int d = 10; d < 16; d++) begin next(); issue_to(d, 0); predict(); end
      next(); predict();
      next(); rst = 0; issue_to(20, 0); source1_ID = 10; predict();
      next(); rst = 1; predict();

      // Randomized traffic over a small register window to force collisions.
      for (int n = 0; n < 3000; n++) begin
         int r;
         next();
         forward_EN    = ($urandom_range(0, 3) != 0);
         issue_valid   = ($urandom_range(0, 9) < 7);
         issue_wb_en   = ($urandom_range(0, 4) != 0);
         issue_is_load = ($urandom_range(0, 9) < 4);
         issue_dest    = 5'($urandom_range(0, 7));
         source1_ID    = 5'($urandom_range(0, 7));
         source2_ID    = 5'($urandom_range(0, 7));
         src2_is_valid = $urandom_range(0, 1);
         r = $urandom_range(0, 7);
         retire_dest  = 5'(r);
         retire_valid = (pend_m[r] > 0 && $urandom_range(0, 1) == 1) ||
                        ($urandom_range(0, 99) == 0);
         r = $urandom_range(0, 7);
         load_done_dest = 5'(r);
         load_done = (lb_m[r] > 0 && $urandom_range(0, 1) == 1) ||
                     ($urandom_range(0, 99) == 0);
         rst = ($urandom_range(0, 299) != 0);
         predict();
      end
      next(); rst = 1; predict();

      @(negedge clk);
      #1;
      chk("queue_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
